// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  localparam logic [63:0] INST_BYTES = 64'd4;
  localparam logic        STOP       = 1'b1;
  localparam logic        NOSTOP     = 1'b0;
  localparam logic        RSTENABLE  = 1'b1;
  localparam logic [31:0] ZERO_32    = 32'h0;
  localparam logic [63:0] ZERO_64    = 64'h0;

  function automatic logic [63:0] word_align(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry {valid, pc, inst} holding register with load and clear.
module if_skid_reg
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        valid,
  output logic [63:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload carries no reset; valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      pc   <= pc_in;
      inst <= inst_in;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch producer: owns the PC, runs one-outstanding req/gnt/rvalid
// fetches and presents {pc, inst} to the IF/ID register, bubbles when empty.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        branch_flag,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc_pc,
  output logic [31:0] pc_instreg_inst
);

  if_state_e   state, nxt, resume;
  logic [63:0] pc_q, pc_nxt, fetch_addr, tgt;
  logic        kill, kill_nxt, req_q;
  logic        redirect, consume;

  logic        out_v, skid_v;
  logic [63:0] out_pc, skid_pc, out_pc_in;
  logic [31:0] out_inst, skid_inst, out_inst_in;
  logic        out_load, out_clr, skid_load, skid_clr;

  logic [3:0]  unused_stall;
  assign unused_stall = stall[5:2];

  assign redirect = flush | branch_flag;
  assign tgt      = word_align(flush ? flush_pc : branch_target);
  assign consume  = out_v && (stall[1] != STOP);
  assign resume   = (stall[0] == NOSTOP) ? IF_REQ : IF_IDLE;

  always_comb begin
    nxt         = state;
    pc_nxt      = pc_q;
    kill_nxt    = kill;
    out_load    = 1'b0;
    out_pc_in   = fetch_addr;
    out_inst_in = imem_rdata;
    skid_load   = 1'b0;
    skid_clr    = redirect;
    if (redirect) begin
      pc_nxt   = tgt;
      nxt      = IF_REQ;
      kill_nxt = 1'b0;
      // A fetch still in flight must have its response swallowed.
      if ((state == IF_REQ && imem_gnt) || (state == IF_WAIT && !imem_rvalid)) begin
        kill_nxt = 1'b1;
        nxt      = IF_WAIT;
      end
    end else begin
      case (state)
        IF_IDLE: if (stall[0] == NOSTOP) nxt = IF_REQ;
        IF_REQ: begin
          if (imem_gnt) begin
            nxt    = IF_WAIT;
            pc_nxt = pc_q + INST_BYTES;
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            nxt = resume;
            if (kill) begin
              kill_nxt = 1'b0;
            end else if (!out_v || consume) begin
              out_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              nxt       = IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (consume) begin
            out_load    = 1'b1;
            out_pc_in   = skid_pc;
            out_inst_in = skid_inst;
            skid_clr    = 1'b1;
            nxt         = resume;
          end
        end
        default: nxt = IF_IDLE;
      endcase
    end
    out_clr = redirect || (consume && !out_load);
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state <= IF_IDLE;
      pc_q  <= RESET_PC;
      kill  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state <= nxt;
      pc_q  <= pc_nxt;
      kill  <= kill_nxt;
      req_q <= (nxt == IF_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IF_REQ && imem_gnt) fetch_addr <= pc_q;
  end

  if_skid_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (out_load),
    .clear   (out_clr),
    .pc_in   (out_pc_in),
    .inst_in (out_inst_in),
    .valid   (out_v),
    .pc      (out_pc),
    .inst    (out_inst)
  );

  if_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clr),
    .pc_in   (fetch_addr),
    .inst_in (imem_rdata),
    .valid   (skid_v),
    .pc      (skid_pc),
    .inst    (skid_inst)
  );

  assign imem_req        = req_q;
  assign imem_addr       = pc_q;
  assign pc_pc           = out_v ? out_pc : ZERO_64;
  assign pc_instreg_inst = out_v ? out_inst : ZERO_32;

  logic unused_skid_v;
  assign unused_skid_v = skid_v;

endmodule
